conv_pool: RTL

Downstream stage of the 6x6/3x3 convolution engine. It consumes the 4x4 map of 20-bit signed results, which arrive serially in row-major order. It applies non-overlapping 2x2 max-pooling, an arithmetic right shift and saturation, and emits a 2x2 map of 8-bit signed values, one per window as each window completes. An optional ReLU sits before the requantizer.

---
 rtl/pool_pkg.sv | 14 +
 rtl/pool_requant.sv | 32 +++
 rtl/conv_pool.sv | 99 +++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared widths, data types and saturation bounds for the conv_pool stage.
// Default widths match the 6x6/3x3 convolution engine upstream.
package pool_pkg;

  localparam int IN_W_DEF  = 20;
  localparam int OUT_W_DEF = 8;

  typedef logic signed [IN_W_DEF-1:0]  conv_data_t;
  typedef logic signed [OUT_W_DEF-1:0] pool_data_t;

  localparam pool_data_t SAT_MAX_DEF = pool_data_t'((1 << (OUT_W_DEF - 1)) - 1);
  localparam pool_data_t SAT_MIN_DEF = pool_data_t'(-(1 << (OUT_W_DEF - 1)));

endpackage

// File: rtl/pool_requant.sv
// Combinational requantizer: optional ReLU (POOL_RELU_EN), arithmetic right
// shift, then saturation from IN_W down to OUT_W signed bits.
module pool_requant
  import pool_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 4
) (
  input  logic signed [IN_W-1:0]  w_i,
  output logic signed [OUT_W-1:0] q_o
);

  // Bounds sign-extended to IN_W so the compare happens before truncation.
  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] relu_w;
  logic signed [IN_W-1:0] shifted;

  always_comb begin
    relu_w = w_i;
`ifdef POOL_RELU_EN
    if (w_i < 0) relu_w = '0;
`endif
    shifted = relu_w >>> SHIFT;
    if (shifted > MAX_V)      q_o = MAX_V[OUT_W-1:0];
    else if (shifted < MIN_V) q_o = MIN_V[OUT_W-1:0];
    else                      q_o = shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/conv_pool.sv
// 2x2 non-overlapping max-pool over a serial row-major IMG_W x IMG_W map,
// followed by requantization (ReLU enabled by defining POOL_RELU_EN).
module conv_pool
  import pool_pkg::*;
#(
  parameter int IMG_W = 4,
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    POOL_start,
  input  logic signed [IN_W-1:0]  POOL_iData,
  output logic                    POOL_oValid,
  output logic signed [OUT_W-1:0] POOL_oData,
  output logic                    POOL_finish
);

  localparam int CNT_W  = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int HALF_W = IMG_W / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(IMG_W - 1);

  // Handshake: a sample is taken on every rising edge with POOL_start=1; there is
  // no ready. POOL_oValid is a one-cycle strobe the consumer must always accept.

  logic [CNT_W-1:0]       row_q, row_d, col_q, col_d;
  logic signed [IN_W-1:0] hold_q, hold_d;
  logic signed [IN_W-1:0] rowbuf_q [HALF_W];
  logic signed [IN_W-1:0] rowbuf_d [HALF_W];
  logic                   valid_q, valid_d, finish_q, finish_d;
  logic signed [OUT_W-1:0] data_q, data_d;

  logic signed [IN_W-1:0]  pair_max, buf_sel, win;
  logic signed [OUT_W-1:0] q_val;
  logic                    win_done;

  pool_requant #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_requant (
    .w_i (win),
    .q_o (q_val)
  );

  always_comb begin
    pair_max = (POOL_iData > hold_q) ? POOL_iData : hold_q;
    buf_sel  = '0;
    for (int i = 0; i < HALF_W; i++)
      if (CNT_W'(i) == (col_q >> 1)) buf_sel = rowbuf_q[i];
    win      = (buf_sel > pair_max) ? buf_sel : pair_max;
    win_done = POOL_start && row_q[0] && col_q[0];

    row_d    = row_q;
    col_d    = col_q;
    hold_d   = hold_q;
    rowbuf_d = rowbuf_q;
    valid_d  = win_done;
    finish_d = win_done && (row_q == LAST) && (col_q == LAST);
    data_d   = win_done ? q_val : data_q;

    if (POOL_start) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CNT_W'(1);
      end else begin
        col_d = col_q + CNT_W'(1);
      end
      if (!col_q[0]) hold_d = POOL_iData;
      // Even rows park the horizontal pair max for the odd row below.
      if (!row_q[0] && col_q[0]) begin
        for (int i = 0; i < HALF_W; i++)
          if (CNT_W'(i) == (col_q >> 1)) rowbuf_d[i] = pair_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_q    <= '0;
      col_q    <= '0;
      hold_q   <= '0;
      for (int i = 0; i < HALF_W; i++) rowbuf_q[i] <= '0;
      valid_q  <= 1'b0;
      finish_q <= 1'b0;
      data_q   <= '0;
    end else begin
      row_q    <= row_d;
      col_q    <= col_d;
      hold_q   <= hold_d;
      rowbuf_q <= rowbuf_d;
      valid_q  <= valid_d;
      finish_q <= finish_d;
      data_q   <= data_d;
    end
  end

  assign POOL_oValid = valid_q;
  assign POOL_oData  = data_q;
  assign POOL_finish = finish_q;

endmodule
